// File: rtl/kanagawa_dsp_arb_pkg.sv
// Shared types for the fmac32 arbiter: FSM state, tag pipeline entry, fp32 constants.
package kanagawa_dsp_arb_pkg;

  localparam int MAX_ID_W = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    OWNED = 1'b1
  } state_t;

  typedef struct packed {
    logic                valid;
    logic [MAX_ID_W-1:0] id;
  } tag_t;

  localparam logic [31:0] FP32_ZERO = 32'h0000_0000;

endpackage

// File: rtl/kanagawa_rr_pick.sv
// Combinational round-robin picker: one-hot grant to the first valid requester
// at or after rr_ptr, wrapping modulo NUM_REQ; all zeros when nothing is valid.
module kanagawa_rr_pick
  import kanagawa_dsp_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] valid,
  input  logic [ID_W-1:0]    rr_ptr,
  output logic [NUM_REQ-1:0] grant
);

  logic [ID_W-1:0] idx;
  logic            found;

  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = ID_W'((int'(rr_ptr) + k) % NUM_REQ);
      if (!found && valid[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/kanagawa_dsp_fmac_arbiter.sv
// Shares one fmac32 among NUM_REQ requesters; a multi-op chain locks the DSP to its owner
// because the accumulator carries state. Only the final sum returns, steered by a tag pipe.
module kanagawa_dsp_fmac_arbiter
  import kanagawa_dsp_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int LATENCY = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_REQ-1:0]      req_valid_in,
  output logic [NUM_REQ-1:0]      req_ready_out,
  input  logic [NUM_REQ*32-1:0]   req_x_in,
  input  logic [NUM_REQ*32-1:0]   req_y_in,
  input  logic [NUM_REQ-1:0]      req_last_in,
  output logic [NUM_REQ-1:0]      resp_valid_out,
  output logic [31:0]             resp_result_out,
  output logic [31:0]             dsp_x_out,
  output logic [31:0]             dsp_y_out,
  output logic                    dsp_accumulate_out,
  output logic                    dsp_valid_out,
  input  logic [31:0]             dsp_result_in,
  output logic                    busy_out
);

  localparam int ID_W = $clog2(NUM_REQ);

  state_t              state;
  logic [ID_W-1:0]     owner;
  logic [ID_W-1:0]     rr_ptr;

  logic [NUM_REQ-1:0]  pick_grant;
  logic [ID_W-1:0]     pick_id;
  logic [ID_W-1:0]     acc_id;
  logic [ID_W-1:0]     rr_next;
  logic                accept;
  logic                acc_last;
  logic [31:0]         acc_x;
  logic [31:0]         acc_y;

  tag_t                tags [LATENCY+1];

  kanagawa_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_pick (
    .valid  (req_valid_in),
    .rr_ptr (rr_ptr),
    .grant  (pick_grant)
  );

  always_comb begin
    pick_id = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick_grant[i]) pick_id = ID_W'(i);
    end
  end

  // Ready is forced low while in reset so every output reads 0 during reset.
  assign req_ready_out = !rst_n           ? '0 :
                         (state == OWNED) ? (NUM_REQ'(1) << owner) :
                                            pick_grant;

  assign acc_id   = (state == OWNED) ? owner : pick_id;
  assign accept   = |(req_valid_in & req_ready_out);
  assign acc_x    = req_x_in[int'(acc_id)*32 +: 32];
  assign acc_y    = req_y_in[int'(acc_id)*32 +: 32];
  assign acc_last = req_last_in[acc_id];
  assign rr_next  = (acc_id == ID_W'(NUM_REQ - 1)) ? '0 : acc_id + ID_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      owner  <= '0;
      rr_ptr <= '0;
    end else if (accept) begin
      case (state)
        IDLE: begin
          if (acc_last) begin
            rr_ptr <= rr_next;
          end else begin
            state <= OWNED;
            owner <= acc_id;
          end
        end
        OWNED: begin
          if (acc_last) begin
            state  <= IDLE;
            rr_ptr <= rr_next;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // The first op of every chain clears the DSP accumulator, so no DSP reset is needed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dsp_valid_out      <= 1'b0;
      dsp_x_out          <= FP32_ZERO;
      dsp_y_out          <= FP32_ZERO;
      dsp_accumulate_out <= 1'b0;
    end else begin
      dsp_valid_out <= accept;
      if (accept) begin
        dsp_x_out          <= acc_x;
        dsp_y_out          <= acc_y;
        dsp_accumulate_out <= (state == OWNED);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k <= LATENCY; k++) tags[k] <= '0;
    end else begin
      tags[0] <= '{valid: accept && acc_last, id: MAX_ID_W'(acc_id)};
      for (int k = 1; k <= LATENCY; k++) tags[k] <= tags[k-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_valid_out  <= '0;
      resp_result_out <= FP32_ZERO;
    end else begin
      resp_valid_out <= tags[LATENCY].valid ? (NUM_REQ'(1) << tags[LATENCY].id) : '0;
      if (tags[LATENCY].valid) resp_result_out <= dsp_result_in;
    end
  end

  always_comb begin
    busy_out = (state == OWNED);
    for (int k = 0; k <= LATENCY; k++) busy_out = busy_out | tags[k].valid;
  end

endmodule

// File: doc/kanagawa_dsp_fmac_arbiter.md
Name: kanagawa_dsp_fmac_arbiter

Overview:
Shares one _hardware_dsp__fmac32 instance among NUM_REQ requesters. Each requester issues a transaction: a chain of one or more multiply-accumulate ops, the final op flagged last. The chain is locked to one requester because the fmac accumulator holds state between ops. Only the final accumulated value is returned, routed back to the owning requester through a tag pipeline aligned to the DSP latency.

Parameters:
NUM_REQ, 4, number of requesters (2..16)
LATENCY, 4, LATENCY of the attached fmac32 instance (>=1)
ID_W, $clog2(NUM_REQ), localparam, requester id width

Ports:
clk  in  1  clock
rst_n  in  1  reset
req_valid_in  in  NUM_REQ  per-requester op valid
req_ready_out  out  NUM_REQ  per-requester accept, at most one bit set
req_x_in  in  NUM_REQ*32  per-requester fp32 multiplicand
req_y_in  in  NUM_REQ*32  per-requester fp32 multiplier
req_last_in  in  NUM_REQ  op closes the requester's chain
resp_valid_out  out  NUM_REQ  one-hot, one-cycle result pulse
resp_result_out  out  32  fp32 final accumulated result, shared bus
dsp_x_out  out  32  to fmac32 op_x_in
dsp_y_out  out  32  to fmac32 op_y_in
dsp_accumulate_out  out  1  to fmac32 op_accumulate_in
dsp_valid_out  out  1  to fmac32 op_valid_in
dsp_result_in  in  32  from fmac32 op_result_out
busy_out  out  1  state==OWNED or any tag in flight

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-low.
- Reset values: every output is 0, state=IDLE, rr_ptr=0, all tags invalid.
- Accept: an op is accepted at an edge where req_valid_in[i] && req_ready_out[i].
- Handshake rules:
  - Ready may depend combinationally on valid.
  - A requester's valid must not depend on its ready.
  - Held x, y and last must stay stable until accepted.
- State IDLE:
  - ready is one-hot to the first valid requester at or after rr_ptr, wrapping modulo NUM_REQ; all zeros if none is valid.
  - On accept from i, issue the op with accumulate=0.
  - If last=1: stay IDLE, rr_ptr<=i+1 mod NUM_REQ.
  - If last=0: go to OWNED, owner<=i.
- State OWNED:
  - req_ready_out[owner]=1 unconditionally; all other ready bits are 0.
  - Accepted ops issue with accumulate=1.
  - Accept with last=1 returns to IDLE, rr_ptr<=owner+1 mod NUM_REQ.
  - Owner bubbles are allowed: dsp_valid_out=0 and state is held. There is no timeout.
- Issue stage (registered):
  - On accept edge t: dsp_x/y/accumulate_out<=accepted op, dsp_valid_out<=1.
  - Otherwise dsp_valid_out<=0 and the dsp data regs hold their values.
  - Peak throughput is one op per cycle, including back-to-back single-op transactions from different requesters.
- Tag pipeline:
  - LATENCY+1 stages of {valid, id}.
  - Stage 0 is loaded at edge t with valid=(accepted && last), id=requester.
  - Stage LATENCY is valid during the cycle after edge t+LATENCY, aligned with dsp_result_in.
- Response (registered):
  - At edge t+LATENCY+1: resp_valid_out<=onehot(id) when the last tag stage is valid, else 0.
  - resp_result_out<=dsp_result_in when the tag is valid, else it holds.
  - Latency from accept edge to resp_valid_out high is LATENCY+1 edges.
  - Non-last ops produce no response.
- Simultaneous events: a last accept and another requester's valid in the same cycle means the other requester is eligible in the next cycle; it is granted then if it is first from the new rr_ptr.
- Reset mid-operation: in-flight tags are discarded and no responses are emitted. The next op issues with accumulate=0, so the DSP accumulator needs no reset.
- No arithmetic is performed in this block; fp32 values pass through unchanged.

Decomposition:
- Package kanagawa_dsp_arb_pkg:
  - state_t enum {IDLE, OWNED}
  - tag_t struct {logic valid; logic [ID_W-1:0] id} (parameterised via a localparam max id width of 4)
  - FP32_ZERO constant
- One sub-module, kanagawa_rr_pick: combinational round-robin picker with inputs valid vector and rr_ptr, output one-hot grant.

Test Plan:
- Single op: NUM_REQ=4, LATENCY=4, req0 x=0x40000000 (2.0), y=0x40400000 (3.0), last=1, accepted at edge 10 -> dsp_valid_out=1 with accumulate=0 after edge 10; resp_valid_out=4'b0001 for one cycle after edge 15; resp_result_out=0x40C00000 (6.0).
- Chain: req1 issues 1.0*1.0, 2.0*2.0, then 0.5*4.0 with last, in consecutive cycles, while req0 holds valid -> dsp_accumulate_out 0,1,1; req_ready_out[0]=0 until after the last accept; one response to req1 with 0x40E00000 (7.0).
- Fairness: all four requesters continuously valid with single-op last=1 transactions -> grants 0,1,2,3,0,1 on consecutive cycles; dsp_valid_out constantly 1; responses arrive in the same order.
- Owner bubble: req2 chain of two ops with a 3-cycle gap, req3 valid throughout -> dsp_valid_out=0 for 3 cycles; req3 is never granted until after req2's last accept; req2 result is correct.
- Reset mid-operation: drive rst_n low with 3 tags in flight and state OWNED -> all outputs 0 immediately; no resp_valid_out after release; req3's first op after release issues with accumulate=0 and returns its plain product.
- Wrap-around: rr_ptr=3, only req0 and req3 valid, both single-op -> grant req3 then req0; rr_ptr becomes 1.
